// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_add_sub_pkg;

  // Control FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit counter width: clog2 of the digit count, never below one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output start, sub, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, sub, a, b, ci,
    output busy, done, s, co, ovf
  );
endinterface

// File: rtl/serial_add_sub_digit_adder.sv
// Combinational ripple-carry adder for one DIGIT-bit slice.
module serial_add_sub_digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_x,
  input  logic [DIGIT-1:0] i_y,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  // Ripple chain of full-adder cells; w_c[i] is the carry into bit i
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < DIGIT; i++) begin
      o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
      w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
    end
  end

  assign o_cout = w_c[DIGIT];
  // Carry into the slice's top bit; on the final digit this is the carry into the MSB
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial two's-complement adder/subtractor with start/busy/done handshake.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  serial_add_sub_if.slave io_bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2) begin : g_bad_params
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e                 r_state, w_state_next;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_a_sh, r_b_sh, r_s_sh, r_s;
  logic                   r_carry, r_co, r_ovf;
  logic                   w_accept, w_last;
  logic [DIGIT-1:0]       w_sum;
  logic                   w_cout, w_cmsb;
  logic [WIDTH+DIGIT-1:0] w_s_cat;
  logic [WIDTH-1:0]       w_s_next;

  assign w_accept = io_bus.start && (r_state == StIdle || r_state == StDone);
  assign w_last   = (r_state == StRun) && (r_cnt == CW'(N - 1));

  // New digit enters at the top, previous digits move down
  assign w_s_cat  = {w_sum, r_s_sh};
  assign w_s_next = WIDTH'(w_s_cat >> DIGIT);

  serial_add_sub_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .i_x    (r_a_sh[DIGIT-1:0]),
    .i_y    (r_b_sh[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (io_bus.start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = io_bus.start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM and result outputs
  always_comb begin
    io_bus.busy = (r_state == StRun);
    io_bus.done = (r_state == StDone);
    io_bus.s    = r_s;
    io_bus.co   = r_co;
    io_bus.ovf  = r_ovf;
  end

  // Operand load, digit shifting and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + 1; ci then acts as a borrow that cancels the +1
      r_a_sh  <= io_bus.a;
      r_b_sh  <= io_bus.sub ? ~io_bus.b : io_bus.b;
      r_carry <= io_bus.ci ^ io_bus.sub;
      r_cnt   <= '0;
    end else if (r_state == StRun) begin
      r_a_sh  <= r_a_sh >> DIGIT;
      r_b_sh  <= r_b_sh >> DIGIT;
      r_s_sh  <= w_s_next;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_s   <= w_s_next;
        r_co  <= w_cout;
        r_ovf <= w_cmsb ^ w_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench: five DUT configurations, table vectors, handshake corners, exhaustive 4-bit.
module tb_serial_add_sub;

  typedef struct {
    int         dut;
    logic [7:0] s;
    logic       co;
    logic       ovf;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  localparam int NDUT = 5;
  // Digits per operation: 8/1, 8/4, 4/1, 4/2, 4/4
  int n_of [NDUT] = '{8, 2, 4, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt [NDUT];
  exp_t scb [$];

  logic       done_v [NDUT];
  logic       busy_v [NDUT];
  logic       co_v   [NDUT];
  logic       ovf_v  [NDUT];
  logic [7:0] s_v    [NDUT];

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8)) if81 ();
  serial_add_sub_if #(.WIDTH(8)) if84 ();
  serial_add_sub_if #(.WIDTH(4)) if41 ();
  serial_add_sub_if #(.WIDTH(4)) if42 ();
  serial_add_sub_if #(.WIDTH(4)) if44 ();

  serial_add_sub #(.WIDTH(8), .DIGIT(1)) u81 (.i_clk(clk), .i_rst(rst), .io_bus(if81));
  serial_add_sub #(.WIDTH(8), .DIGIT(4)) u84 (.i_clk(clk), .i_rst(rst), .io_bus(if84));
  serial_add_sub #(.WIDTH(4), .DIGIT(1)) u41 (.i_clk(clk), .i_rst(rst), .io_bus(if41));
  serial_add_sub #(.WIDTH(4), .DIGIT(2)) u42 (.i_clk(clk), .i_rst(rst), .io_bus(if42));
  serial_add_sub #(.WIDTH(4), .DIGIT(4)) u44 (.i_clk(clk), .i_rst(rst), .io_bus(if44));

  assign done_v[0] = if81.done; assign busy_v[0] = if81.busy; assign s_v[0] = if81.s;
  assign done_v[1] = if84.done; assign busy_v[1] = if84.busy; assign s_v[1] = if84.s;
  assign done_v[2] = if41.done; assign busy_v[2] = if41.busy; assign s_v[2] = {4'b0, if41.s};
  assign done_v[3] = if42.done; assign busy_v[3] = if42.busy; assign s_v[3] = {4'b0, if42.s};
  assign done_v[4] = if44.done; assign busy_v[4] = if44.busy; assign s_v[4] = {4'b0, if44.s};
  assign co_v[0] = if81.co; assign co_v[1] = if84.co; assign co_v[2] = if41.co;
  assign co_v[3] = if42.co; assign co_v[4] = if44.co;
  assign ovf_v[0] = if81.ovf; assign ovf_v[1] = if84.ovf; assign ovf_v[2] = if41.ovf;
  assign ovf_v[3] = if42.ovf; assign ovf_v[4] = if44.ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural reference: integer arithmetic, borrow and signed range
  function automatic exp_t model(input int w, input int d, input int a, input int b,
                                 input int ci, input int sub);
    exp_t e;
    int   res, sa, sbv, sres, half;
    half  = 1 << (w - 1);
    res   = (sub != 0) ? a - b - ci : a + b + ci;
    e.dut = d;
    e.cyc = 0;
    e.s   = 8'(res & ((1 << w) - 1));
    e.co  = (sub != 0) ? (res >= 0) : (res >= (1 << w));
    sa    = (a >= half) ? a - 2 * half : a;
    sbv   = (b >= half) ? b - 2 * half : b;
    sres  = (sub != 0) ? sa - sbv - ci : sa + sbv + ci;
    e.ovf = (sres < -half) || (sres > half - 1);
    return e;
  endfunction

  // Advance to the next falling edge and score every DUT that shows done
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (busy_v[d] === 1'b1) busy_cnt[d]++;
      if (done_v[d] === 1'b1) begin
        int idx = -1;
        chk($sformatf("busy_with_done[%0d]", d), 32'(busy_v[d]), 32'd0);
        for (int k = 0; k < scb.size(); k++) if (idx < 0 && scb[k].dut == d) idx = k;
        if (idx < 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done[%0d]: got done=1 want done=0 (cycle %0d)", d, cyc);
        end else begin
          e = scb[idx];
          scb.delete(idx);
          chk($sformatf("s[%0d]", d), 32'(s_v[d]), 32'(e.s));
          chk($sformatf("co[%0d]", d), 32'(co_v[d]), 32'(e.co));
          chk($sformatf("ovf[%0d]", d), 32'(ovf_v[d]), 32'(e.ovf));
          chk($sformatf("done_cycle[%0d]", d), cyc, e.cyc);
          chk($sformatf("busy_cycles[%0d]", d), busy_cnt[d], n_of[d]);
        end
        busy_cnt[d] = 0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (scb.size() > 0 && t < budget) begin
      step();
      t++;
    end
    if (scb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending results want 0", scb.size());
      scb.delete();
    end
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic sub, input logic [7:0] es, input logic eco,
                        input logic eovf, input bit use4);
    exp_t e;
    if81.a = a; if81.b = b; if81.ci = ci; if81.sub = sub; if81.start = 1'b1;
    if84.a = a; if84.b = b; if84.ci = ci; if84.sub = sub; if84.start = use4;
    e.s = es; e.co = eco; e.ovf = eovf;
    e.dut = 0; e.cyc = cyc + 1 + n_of[0]; scb.push_back(e);
    if (use4) begin
      e.dut = 1; e.cyc = cyc + 1 + n_of[1]; scb.push_back(e);
    end
    step();
    if81.start = 1'b0;
    if84.start = 1'b0;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic sub);
    exp_t e;
    if41.a = a; if41.b = b; if41.ci = ci; if41.sub = sub; if41.start = 1'b1;
    if42.a = a; if42.b = b; if42.ci = ci; if42.sub = sub; if42.start = 1'b1;
    if44.a = a; if44.b = b; if44.ci = ci; if44.sub = sub; if44.start = 1'b1;
    for (int d = 2; d < NDUT; d++) begin
      e = model(4, d, int'(a), int'(b), int'(ci), int'(sub));
      e.cyc = cyc + 1 + n_of[d];
      scb.push_back(e);
    end
    step();
    if41.start = 1'b0;
    if42.start = 1'b0;
    if44.start = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{a: 8'h5A, b: 8'h3C, ci: 1'b0, sub: 1'b0, s: 8'h96, co: 1'b0, ovf: 1'b1};
    tbl[1] = '{a: 8'h10, b: 8'h20, ci: 1'b0, sub: 1'b1, s: 8'hF0, co: 1'b0, ovf: 1'b0};
    tbl[2] = '{a: 8'h80, b: 8'h01, ci: 1'b0, sub: 1'b1, s: 8'h7F, co: 1'b1, ovf: 1'b1};
    tbl[3] = '{a: 8'hFF, b: 8'h01, ci: 1'b1, sub: 1'b0, s: 8'h01, co: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: 8'h7F, b: 8'h01, ci: 1'b0, sub: 1'b0, s: 8'h80, co: 1'b0, ovf: 1'b1};
    tbl[5] = '{a: 8'h00, b: 8'h00, ci: 1'b1, sub: 1'b1, s: 8'hFF, co: 1'b0, ovf: 1'b0};
    tbl[6] = '{a: 8'hC0, b: 8'hC0, ci: 1'b0, sub: 1'b0, s: 8'h80, co: 1'b1, ovf: 1'b0};
    tbl[7] = '{a: 8'h7F, b: 8'hFF, ci: 1'b0, sub: 1'b1, s: 8'h80, co: 1'b0, ovf: 1'b1};

    if81.start = 0; if81.sub = 0; if81.a = 0; if81.b = 0; if81.ci = 0;
    if84.start = 0; if84.sub = 0; if84.a = 0; if84.b = 0; if84.ci = 0;
    if41.start = 0; if41.sub = 0; if41.a = 0; if41.b = 0; if41.ci = 0;
    if42.start = 0; if42.sub = 0; if42.a = 0; if42.b = 0; if42.ci = 0;
    if44.start = 0; if44.sub = 0; if44.a = 0; if44.b = 0; if44.ci = 0;
    for (int d = 0; d < NDUT; d++) busy_cnt[d] = 0;

    // Reset state of every configuration
    rst = 1'b1;
    step();
    step();
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("rst_done[%0d]", d), 32'(done_v[d]), 32'd0);
      chk($sformatf("rst_s[%0d]", d), 32'(s_v[d]), 32'd0);
      chk($sformatf("rst_co[%0d]", d), 32'(co_v[d]), 32'd0);
      chk($sformatf("rst_ovf[%0d]", d), 32'(ovf_v[d]), 32'd0);
    end
    rst = 1'b0;
    step();

    // Table vectors on both 8-bit configurations
    for (int i = 0; i < 8; i++) begin
      drive8(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sub, tbl[i].s, tbl[i].co, tbl[i].ovf, 1'b1);
      drain(30);
    end
    repeat (3) step();

    // start during RUN (cycle 3) with other operands is ignored
    drive8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    step();
    step();
    if81.a = 8'h01; if81.b = 8'h01; if81.ci = 1'b1; if81.sub = 1'b1; if81.start = 1'b1;
    step();
    if81.start = 1'b0;
    drain(20);
    repeat (12) step();

    // Back-to-back: new start in the done cycle
    drive8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0);
    drain(20);
    drive8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    chk("b2b_busy", 32'(busy_v[0]), 32'd1);
    chk("b2b_done", 32'(done_v[0]), 32'd0);
    drain(20);
    repeat (3) step();

    // Reset in RUN cycle 4 discards the partial result
    drive8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    chk("midrst_s", 32'(s_v[0]), 32'd0);
    chk("midrst_co", 32'(co_v[0]), 32'd0);
    chk("midrst_ovf", 32'(ovf_v[0]), 32'd0);
    rst = 1'b0;
    scb.delete();
    for (int d = 0; d < NDUT; d++) busy_cnt[d] = 0;
    repeat (12) step();

    // Exhaustive 4-bit against the behavioural model, DIGIT = 1, 2, 4
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++)
          for (int sub = 0; sub < 2; sub++) begin
            drive4(4'(a), 4'(b), 1'(ci), 1'(sub));
            drain(20);
          end

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
